// File: rtl/pix_proc_sched.sv
// pix_proc_sched: frame scheduler for the colour-reduction pipeline.
// Streams bank-0 words through the pixel processor into bank 1 via a skid FIFO.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle pulse, begins a frame pass
//   b0_rd_en/addr     bank-0 read strobe and address (registered)
//   proc_addr_in      b0_rd_addr delayed ZBT_LAT cycles, to the processor
//   proc_data/addr    processed word and its address from the processor
//   disp_req/addr     display claim on bank 1 (absolute priority)
//   b1_addr/we/wdata  bank-1 port (registered)
//   busy, done        frame in progress / one-cycle completion pulse
module pix_proc_sched #(
    parameter logic [18:0] NUM_WORDS  = 19'd153600,
    parameter int          ZBT_LAT    = 2,
    parameter int          PROC_LAT   = 1,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        b0_rd_en,
    output logic [18:0] b0_rd_addr,
    output logic [18:0] proc_addr_in,
    input  logic [35:0] proc_data,
    input  logic [18:0] proc_addr,
    input  logic        disp_req,
    input  logic [18:0] disp_addr,
    output logic [18:0] b1_addr,
    output logic        b1_we,
    output logic [35:0] b1_wdata,
    output logic        busy,
    output logic        done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int VL = ZBT_LAT + PROC_LAT;
    localparam logic [19:0] DEPTH_W = 20'(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [18:0]   r_issue_cnt;
    logic [18:0]   r_inflight;
    logic          r_b0_rd_en;
    logic [18:0]   r_b0_rd_addr;
    logic [VL-1:0] r_vld;
    logic [18:0]   r_adly [ZBT_LAT];
    logic [54:0]   r_mem  [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [18:0]   r_b1_addr;
    logic          r_b1_we;
    logic [35:0]   r_b1_wdata;

    logic          w_issue;
    logic          w_last;
    logic          w_ret;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_drained;
    logic [19:0]   w_used;

    // Words returning or queued plus reads in flight: bounded by the
    // FIFO depth so a push always finds room.
    assign w_used    = {1'b0, r_inflight} + 20'(r_count);
    assign w_issue   = (r_state == S_RUN) && (w_used < DEPTH_W);
    assign w_last    = (r_issue_cnt == NUM_WORDS - 19'd1);
    assign w_ret     = r_vld[VL-1];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_push    = w_ret && !w_full;
    assign w_pop     = !disp_req && !w_empty;
    // The last popped word sits in the bank-1 register during the cycle
    // the FIFO first reads empty; that write completes this cycle, so
    // DONE follows directly.
    assign w_drained = (r_inflight == '0) && w_empty;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_issue && w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_drained) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // Issue path and in-flight accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_cnt  <= '0;
            r_inflight   <= '0;
            r_b0_rd_en   <= 1'b0;
            r_b0_rd_addr <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_issue_cnt <= '0;
            end else if (w_issue && !w_last) begin
                r_issue_cnt <= r_issue_cnt + 19'd1;
            end
            r_b0_rd_en <= w_issue;
            if (w_issue) begin
                r_b0_rd_addr <= r_issue_cnt;
            end
            unique case ({w_issue, w_ret})
                2'b10:   r_inflight <= r_inflight + 19'd1;
                2'b01:   r_inflight <= r_inflight - 19'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Valid and address delay lines
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            for (int i = 0; i < ZBT_LAT; i++) begin
                r_adly[i] <= '0;
            end
        end else begin
            r_vld     <= (r_vld << 1) | VL'(r_b0_rd_en);
            r_adly[0] <= r_b0_rd_addr;
            for (int i = 1; i < ZBT_LAT; i++) begin
                r_adly[i] <= r_adly[i-1];
            end
        end
    end

    // Skid FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {proc_addr, proc_data};
        end
    end

    // Skid FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bank-1 arbitration, display first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b1_addr  <= '0;
            r_b1_we    <= 1'b0;
            r_b1_wdata <= '0;
        end else if (disp_req) begin
            r_b1_addr <= disp_addr;
            r_b1_we   <= 1'b0;
        end else if (!w_empty) begin
            r_b1_we                 <= 1'b1;
            {r_b1_addr, r_b1_wdata} <= r_mem[r_rptr];
        end else begin
            r_b1_we <= 1'b0;
        end
    end

    assign b0_rd_en     = r_b0_rd_en;
    assign b0_rd_addr   = r_b0_rd_addr;
    assign proc_addr_in = r_adly[ZBT_LAT-1];
    assign b1_addr      = r_b1_addr;
    assign b1_we        = r_b1_we;
    assign b1_wdata     = r_b1_wdata;

endmodule

// File: tb/tb_pix_proc_sched.sv
// tb_pix_proc_sched: self-checking bench for pix_proc_sched.
// Models bank 0 and the pixel processor; checks bank-1 traffic per frame.
module tb_pix_proc_sched;
    localparam int          N    = 16;
    localparam logic [35:0] MASK = 36'hE38E38E38;
    localparam int          LOGN = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        b0_rd_en;
    logic [18:0] b0_rd_addr;
    logic [18:0] proc_addr_in;
    logic [35:0] proc_data;
    logic [18:0] proc_addr;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic [18:0] b1_addr;
    logic        b1_we;
    logic [35:0] b1_wdata;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    pix_proc_sched #(
        .NUM_WORDS (19'd16),
        .FIFO_DEPTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .b0_rd_en    (b0_rd_en),
        .b0_rd_addr  (b0_rd_addr),
        .proc_addr_in(proc_addr_in),
        .proc_data   (proc_data),
        .proc_addr   (proc_addr),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .b1_addr     (b1_addr),
        .b1_we       (b1_we),
        .b1_wdata    (b1_wdata),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Bank 0: two-cycle read pipeline. Processor: one registered stage.
    logic [35:0] mem0 [N];
    logic [35:0] zbt_s1;
    logic [35:0] zbt_q;
    always @(posedge clk) begin
        zbt_s1    <= mem0[b0_rd_addr[3:0]];
        zbt_q     <= zbt_s1;
        proc_data <= zbt_q & MASK;
        proc_addr <= proc_addr_in;
    end

    // Per-cycle trace, sampled mid-cycle
    int          cyc = 0;
    logic        lg_en   [LOGN];
    logic [18:0] lg_ra   [LOGN];
    logic        lg_we   [LOGN];
    logic [18:0] lg_b1a  [LOGN];
    logic [35:0] lg_wd   [LOGN];
    logic        lg_done [LOGN];
    logic        lg_busy [LOGN];
    logic        lg_disp [LOGN];
    logic [18:0] lg_da   [LOGN];
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            lg_en[cyc]   = b0_rd_en;
            lg_ra[cyc]   = b0_rd_addr;
            lg_we[cyc]   = b1_we;
            lg_b1a[cyc]  = b1_addr;
            lg_wd[cyc]   = b1_wdata;
            lg_done[cyc] = done;
            lg_busy[cyc] = busy;
            lg_disp[cyc] = disp_req;
            lg_da[cyc]   = disp_addr;
        end
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    logic [18:0] rd_a [$];
    int          rd_c [$];
    logic [18:0] wr_a [$];
    logic [35:0] wr_d [$];
    int          wr_c [$];
    int          dn_c [$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_mem();
        logic [63:0] r;
        for (int i = 0; i < N; i++) begin
            r = {$urandom, $urandom};
            mem0[i] = r[35:0];
        end
    endtask

    task automatic extract(input int s, input int e);
        rd_a.delete(); rd_c.delete();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        dn_c.delete();
        for (int k = s; k < e && k < LOGN; k++) begin
            if (lg_en[k] === 1'b1) begin
                rd_a.push_back(lg_ra[k]);
                rd_c.push_back(k);
            end
            if (lg_we[k] === 1'b1) begin
                wr_a.push_back(lg_b1a[k]);
                wr_d.push_back(lg_wd[k]);
                wr_c.push_back(k);
            end
            if (lg_done[k] === 1'b1) dn_c.push_back(k);
        end
    endtask

    // mode 0: no display; 1: 20-cycle display burst from the third read;
    // 2: display toggling; 3: extra start pulses while busy.
    task automatic run_frame(input int mode, output int s,
                             output int e, output bit ok);
        int rem;
        bit fired;
        int post;
        ok    = 1'b0;
        rem   = 0;
        fired = 1'b0;
        post  = -1;
        s     = cyc;
        start     = 1'b1;
        disp_req  = 1'b0;
        disp_addr = 19'($urandom);
        for (int k = 0; k < 600; k++) begin
            tick();
            start = (mode == 3) && (k == 3 || k == 10);
            if (mode == 1 && !fired && b0_rd_en && b0_rd_addr == 19'd2) begin
                fired = 1'b1;
                rem   = 20;
            end
            case (mode)
                1: begin
                    disp_req = (rem > 0);
                    if (rem > 0) rem--;
                end
                2:       disp_req = ~disp_req;
                default: disp_req = 1'b0;
            endcase
            disp_addr = 19'($urandom);
            if (done === 1'b1 && post < 0) post = 4;
            if (post == 0) begin
                ok = 1'b1;
                break;
            end
            if (post > 0) post--;
        end
        disp_req = 1'b0;
        start    = 1'b0;
        e        = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; disp_req = 1'b0; disp_addr = '0;
        repeat (3) tick();
        n_chk++; if (b0_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_b0_rd_en: got %b want 0", b0_rd_en); end
        n_chk++; if (b0_rd_addr !== '0) begin n_fail++; $display("FAIL rst_b0_rd_addr: got %h want 0", b0_rd_addr); end
        n_chk++; if (proc_addr_in !== '0) begin n_fail++; $display("FAIL rst_proc_addr_in: got %h want 0", proc_addr_in); end
        n_chk++; if (b1_addr !== '0) begin n_fail++; $display("FAIL rst_b1_addr: got %h want 0", b1_addr); end
        n_chk++; if (b1_we !== 1'b0) begin n_fail++; $display("FAIL rst_b1_we: got %b want 0", b1_we); end
        n_chk++; if (b1_wdata !== '0) begin n_fail++; $display("FAIL rst_b1_wdata: got %h want 0", b1_wdata); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int s, e;
        bit ok;
        fill_mem();
        run_frame(0, s, e, ok);
        extract(s, e);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_done_seen: got 0 want 1"); end
        n_chk++; if (rd_a.size() != N) begin n_fail++; $display("FAIL basic_rd_count: got %0d want %0d", rd_a.size(), N); end
        for (int i = 0; i < rd_a.size(); i++) begin
            n_chk++;
            if (rd_a[i] !== 19'(i) || rd_c[i] != rd_c[0] + i) begin
                n_fail++; $display("FAIL basic_rd[%0d]: got addr %0d cyc +%0d want addr %0d cyc +%0d", i, rd_a[i], rd_c[i] - rd_c[0], i, i);
            end
        end
        n_chk++;
        if (rd_c.size() == 0 || wr_c.size() == 0 || wr_c[0] - rd_c[0] != 5) begin
            n_fail++; $display("FAIL basic_latency: got %0d want 5", (rd_c.size() && wr_c.size()) ? wr_c[0] - rd_c[0] : -1);
        end
        n_chk++; if (wr_a.size() != N) begin n_fail++; $display("FAIL basic_wr_count: got %0d want %0d", wr_a.size(), N); end
        for (int i = 0; i < wr_a.size(); i++) begin
            n_chk++;
            if (i >= N || wr_a[i] !== 19'(i) || wr_d[i] !== (mem0[i] & MASK)) begin
                n_fail++; $display("FAIL basic_wr[%0d]: got %0d/%h want %0d/%h", i, wr_a[i], wr_d[i], i, mem0[i % N] & MASK);
            end
        end
        n_chk++; if (dn_c.size() != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", dn_c.size()); end
        n_chk++;
        if (dn_c.size() == 0 || wr_c.size() == 0 || dn_c[0] != wr_c[wr_c.size()-1] + 1) begin
            n_fail++; $display("FAIL basic_done_timing: done not the cycle after the last write");
        end
        if (dn_c.size() > 0) begin
            n_chk++;
            if (lg_busy[dn_c[0]] !== 1'b1 || lg_busy[dn_c[0]+1] !== 1'b0) begin
                n_fail++; $display("FAIL basic_busy_drop: got %b%b want 10", lg_busy[dn_c[0]], lg_busy[dn_c[0]+1]);
            end
        end
    endtask

    task automatic test_disp_stall();
        int s, e, nd, last, nr;
        bit ok;
        fill_mem();
        run_frame(1, s, e, ok);
        extract(s, e);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL stall_done_seen: got 0 want 1"); end
        nd = 0; last = -1;
        for (int k = s + 1; k < e; k++) begin
            if (lg_disp[k-1] === 1'b1) begin
                nd++; last = k - 1;
                n_chk++;
                if (lg_we[k] !== 1'b0 || lg_b1a[k] !== lg_da[k-1]) begin
                    n_fail++; $display("FAIL stall_disp_cyc%0d: got we=%b addr=%h want we=0 addr=%h", k - s, lg_we[k], lg_b1a[k], lg_da[k-1]);
                end
            end
        end
        n_chk++; if (nd != 20) begin n_fail++; $display("FAIL stall_disp_len: got %0d want 20", nd); end
        nr = 0;
        foreach (rd_c[i]) if (rd_c[i] <= last) nr++;
        n_chk++; if (nr != 8) begin n_fail++; $display("FAIL stall_credit: got %0d reads want 8", nr); end
        n_chk++; if (rd_a.size() != N) begin n_fail++; $display("FAIL stall_rd_count: got %0d want %0d", rd_a.size(), N); end
        for (int i = 0; i < rd_a.size(); i++) begin
            n_chk++;
            if (rd_a[i] !== 19'(i)) begin n_fail++; $display("FAIL stall_rd[%0d]: got %0d want %0d", i, rd_a[i], i); end
        end
        n_chk++; if (wr_a.size() != N) begin n_fail++; $display("FAIL stall_wr_count: got %0d want %0d", wr_a.size(), N); end
        for (int i = 0; i < wr_a.size(); i++) begin
            n_chk++;
            if (i >= N || wr_a[i] !== 19'(i) || wr_d[i] !== (mem0[i] & MASK)) begin
                n_fail++; $display("FAIL stall_wr[%0d]: got %0d/%h want %0d/%h", i, wr_a[i], wr_d[i], i, mem0[i % N] & MASK);
            end
        end
        n_chk++; if (dn_c.size() != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", dn_c.size()); end
    endtask

    task automatic test_toggle();
        int s, e;
        bit ok;
        fill_mem();
        run_frame(2, s, e, ok);
        extract(s, e);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL toggle_done_seen: got 0 want 1"); end
        foreach (wr_c[i]) begin
            n_chk++;
            if (lg_disp[wr_c[i]-1] !== 1'b0) begin
                n_fail++; $display("FAIL toggle_wr_slot[%0d]: prior disp_req=%b want 0", i, lg_disp[wr_c[i]-1]);
            end
        end
        for (int k = s + 1; k < e; k++) begin
            if (lg_disp[k-1] === 1'b1) begin
                n_chk++;
                if (lg_we[k] !== 1'b0 || lg_b1a[k] !== lg_da[k-1]) begin
                    n_fail++; $display("FAIL toggle_disp_cyc%0d: got we=%b addr=%h want we=0 addr=%h", k - s, lg_we[k], lg_b1a[k], lg_da[k-1]);
                end
            end
        end
        n_chk++; if (wr_a.size() != N) begin n_fail++; $display("FAIL toggle_wr_count: got %0d want %0d", wr_a.size(), N); end
        for (int i = 0; i < wr_a.size(); i++) begin
            n_chk++;
            if (i >= N || wr_a[i] !== 19'(i) || wr_d[i] !== (mem0[i] & MASK)) begin
                n_fail++; $display("FAIL toggle_wr[%0d]: got %0d/%h want %0d/%h", i, wr_a[i], wr_d[i], i, mem0[i % N] & MASK);
            end
        end
        n_chk++; if (dn_c.size() != 1) begin n_fail++; $display("FAIL toggle_done_count: got %0d want 1", dn_c.size()); end
    endtask

    task automatic test_reset_mid();
        int s, e;
        bit ok, found;
        fill_mem();
        found = 1'b0;
        start = 1'b1; disp_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            start = 1'b0;
            if (b0_rd_en && b0_rd_addr == 19'd7) begin
                found = 1'b1;
                break;
            end
        end
        n_chk++; if (!found) begin n_fail++; $display("FAIL rmid_read7: got none want one"); end
        reset = 1'b1;
        tick();
        n_chk++;
        if ({b0_rd_en, b0_rd_addr, proc_addr_in, b1_addr, b1_we, b1_wdata, busy, done} !== '0) begin
            n_fail++; $display("FAIL rmid_outputs: got en=%b ra=%h pa=%h ba=%h we=%b wd=%h busy=%b done=%b want all 0",
                               b0_rd_en, b0_rd_addr, proc_addr_in, b1_addr, b1_we, b1_wdata, busy, done);
        end
        reset = 1'b0;
        s = cyc;
        repeat (12) tick();
        extract(s, cyc);
        n_chk++; if (wr_a.size() != 0) begin n_fail++; $display("FAIL rmid_stray_wr: got %0d want 0", wr_a.size()); end
        n_chk++; if (rd_a.size() != 0) begin n_fail++; $display("FAIL rmid_stray_rd: got %0d want 0", rd_a.size()); end
        run_frame(0, s, e, ok);
        extract(s, e);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_done_seen: got 0 want 1"); end
        n_chk++;
        if (rd_a.size() != N || rd_a[0] !== 19'd0) begin
            n_fail++; $display("FAIL rmid_reread: got %0d reads first %0d want %0d first 0", rd_a.size(), rd_a.size() ? rd_a[0] : 19'h7FFFF, N);
        end
        n_chk++; if (wr_a.size() != N) begin n_fail++; $display("FAIL rmid_wr_count: got %0d want %0d", wr_a.size(), N); end
        for (int i = 0; i < wr_a.size(); i++) begin
            n_chk++;
            if (i >= N || wr_a[i] !== 19'(i) || wr_d[i] !== (mem0[i] & MASK)) begin
                n_fail++; $display("FAIL rmid_wr[%0d]: got %0d/%h want %0d/%h", i, wr_a[i], wr_d[i], i, mem0[i % N] & MASK);
            end
        end
    endtask

    task automatic test_start_ignore();
        int s, e;
        bit ok;
        fill_mem();
        run_frame(3, s, e, ok);
        extract(s, e);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL sig_done_seen: got 0 want 1"); end
        n_chk++; if (rd_a.size() != N) begin n_fail++; $display("FAIL sig_rd_count: got %0d want %0d", rd_a.size(), N); end
        n_chk++; if (wr_a.size() != N) begin n_fail++; $display("FAIL sig_wr_count: got %0d want %0d", wr_a.size(), N); end
        for (int i = 0; i < wr_a.size(); i++) begin
            n_chk++;
            if (i >= N || wr_a[i] !== 19'(i) || wr_d[i] !== (mem0[i] & MASK)) begin
                n_fail++; $display("FAIL sig_wr[%0d]: got %0d/%h want %0d/%h", i, wr_a[i], wr_d[i], i, mem0[i % N] & MASK);
            end
        end
        n_chk++; if (dn_c.size() != 1) begin n_fail++; $display("FAIL sig_done_count: got %0d want 1", dn_c.size()); end
        start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || b0_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL sig_start_reset: got busy=%b en=%b want 0 0", busy, b0_rd_en);
        end
        repeat (4) tick();
        n_chk++;
        if (busy !== 1'b0 || b0_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL sig_stay_idle: got busy=%b en=%b want 0 0", busy, b0_rd_en);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        fill_mem();
        test_reset();
        test_basic();
        test_disp_stall();
        test_toggle();
        test_reset_mid();
        test_start_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
